// File: rtl/reflet_timer_pkg.sv
// Shared register map, CTRL layout and decode constants for the Reflet bus timer.
package reflet_timer_pkg;

    // Register indices as seen through the word-aligned decode window
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_PRESC  = 3'd1,
        REG_CMP    = 3'd2,
        REG_COUNT  = 3'd3,
        REG_STATUS = 3'd4
    } reg_idx_t;

    localparam int NUM_REGS = 5;

    // CTRL bit positions
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_AUTO_BIT     = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int CTRL_IRQ_LINE_LO  = 3;
    localparam int CTRL_IRQ_LINE_HI  = 4;
    localparam int CTRL_WIDTH        = 5;

    // Packed view of CTRL; the field order places en at bit 0 and irq_line at [4:3]
    typedef struct packed {
        logic [1:0] irq_line;
        logic       irq_en;
        logic       auto_reload;
        logic       en;
    } ctrl_t;

    // STATUS bit positions
    localparam int STATUS_MATCH_BIT = 0;

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Prescaler: counts 0..limit while enabled and pulses tick on the terminal count.
module reflet_timer_prescaler
    import reflet_timer_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    input  logic         clear_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Tick is decided on the current count so a limit of 0 ticks every enabled cycle
    assign tick_o = en_i && (cnt_q == limit_i);

    // Next count: clear has priority, otherwise wrap on tick or advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == limit_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reflet_timer_responder.sv
// Memory-mapped timer on the Reflet bus: decode, register file, compare/reload logic and irq routing.
// Bus contract: no ready/valid; every access is answered with data_out one cycle after addr presents.
module reflet_timer_responder
    import reflet_timer_pkg::*;
#(
    parameter int                    wordsize  = 16,
    parameter logic [wordsize-1:0]   base_addr = {wordsize{1'b1}} - wordsize'(15)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic [3:0]          irq
);

    localparam logic [wordsize-1:0] STRIDE = wordsize'(wordsize / 8);
    localparam logic [wordsize-1:0] NREGS  = wordsize'(NUM_REGS);

    ctrl_t               ctrl_q,  ctrl_d;
    logic [wordsize-1:0] presc_q, presc_d;
    logic [wordsize-1:0] cmp_q,   cmp_d;
    logic [wordsize-1:0] count_q, count_d;
    logic                match_q, match_d;
    logic [3:0]          irq_q,   irq_d;
    logic [wordsize-1:0] dout_q,  dout_d;

    logic [wordsize-1:0] offset;
    logic [wordsize-1:0] idx_full;
    logic                sel;
    reg_idx_t            idx;
    logic [wordsize-1:0] rd_word;
    logic                wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
    logic                tick;
    logic                match_set;

    // Address decode: in-window, word-aligned addresses select one of the five registers
    always_comb begin
        offset   = addr - base_addr;
        idx_full = offset / STRIDE;
        sel      = (addr >= base_addr) && (idx_full < NREGS) && ((offset % STRIDE) == '0);
        idx      = reg_idx_t'(idx_full[2:0]);
    end

    assign wr_ctrl   = write_en && sel && (idx == REG_CTRL);
    assign wr_presc  = write_en && sel && (idx == REG_PRESC);
    assign wr_cmp    = write_en && sel && (idx == REG_CMP);
    assign wr_count  = write_en && sel && (idx == REG_COUNT);
    assign wr_status = write_en && sel && (idx == REG_STATUS);

    // Writing CTRL or PRESC restarts the prescaler so the first period after setup is full length
    reflet_timer_prescaler #(
        .W (wordsize)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ctrl_q.en),
        .limit_i (presc_q),
        .clear_i (wr_ctrl || wr_presc),
        .tick_o  (tick)
    );

    // Read mux: unused bits of CTRL and STATUS read as 0
    always_comb begin
        rd_word = '0;
        case (idx)
            REG_CTRL:   rd_word[CTRL_WIDTH-1:0] = ctrl_q;
            REG_PRESC:  rd_word = presc_q;
            REG_CMP:    rd_word = cmp_q;
            REG_COUNT:  rd_word = count_q;
            REG_STATUS: rd_word[STATUS_MATCH_BIT] = match_q;
            default:    rd_word = '0;
        endcase
    end

    // Next-state: counting first, then CPU writes override (write beats tick, set beats W1C)
    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        cmp_d     = cmp_q;
        count_d   = count_q;
        match_set = 1'b0;

        if (tick) begin
            if (count_q == cmp_q) begin
                match_set = 1'b1;
                if (ctrl_q.auto_reload) begin
                    count_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if (wr_ctrl)  ctrl_d  = ctrl_t'(data_in[CTRL_WIDTH-1:0]);
        if (wr_presc) presc_d = data_in;
        if (wr_cmp)   cmp_d   = data_in;
        if (wr_count) count_d = data_in;

        match_d = match_q;
        if (wr_status && data_in[STATUS_MATCH_BIT]) match_d = 1'b0;
        if (match_set) match_d = 1'b1;

        // irq follows the next-state match/CTRL so it moves on the same edge they do
        irq_d = '0;
        if (match_d && ctrl_d.irq_en) irq_d[ctrl_d.irq_line] = 1'b1;

        dout_d = sel ? rd_word : '0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            irq_q   <= '0;
            dout_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            match_q <= match_d;
            irq_q   <= irq_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out = dout_q;
    assign irq      = irq_q;

endmodule
